// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: state/opcode encoding,
// state width and flag bit positions.
package alu_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_ADD  = 3'd0,
        S_SUB  = 3'd1,
        S_AND  = 3'd2,
        S_OR   = 3'd3,
        S_XOR  = 3'd4,
        S_NOTA = 3'd5,
        S_SHL  = 3'd6,
        S_SHR  = 3'd7
    } state_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    function automatic state_t state_succ(input state_t s);
        return state_t'(s + STATE_W'(1));
    endfunction

endpackage

// File: rtl/alu_sequencer_tick_gen.sv
// Clock-enable generator: one-cycle pulse every TICK_DIV board clocks.
// clear holds the count at zero so re-enabling yields a full period.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock50Mhz,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock50Mhz) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/alu_sequencer.sv
// Eight-operation ALU sequencer with tick-driven auto stepping,
// debounced-by-edge manual stepping, hold and registered status flags.
module alu_sequencer #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clock50Mhz,
    input  logic             reset,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             mode,
    input  logic             step,
    input  logic             hold,
    output logic [WIDTH-1:0] AluOut,
    output logic [3:0]       Flags,
    output logic [2:0]       PrStateLed,
    output logic [2:0]       NxStateLed,
    output logic             tick
);

    import alu_seq_pkg::*;

    localparam int M = WIDTH - 1;

    state_t state, state_nx;
    logic   tick_w;
    logic   sync1, sync2, prev;
    logic   seen, armed;
    logic   step_rise;
    logic   advance;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clock50Mhz(clock50Mhz),
        .reset     (reset),
        .clear     (mode),
        .tick      (tick_w)
    );

    // armed only sets once a genuinely sampled low has reached sync1,
    // so a button held across reset release never counts as a press.
    always_ff @(posedge clock50Mhz) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            seen  <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync1 <= step;
            sync2 <= sync1;
            prev  <= sync2;
            seen  <= 1'b1;
            armed <= armed | (seen & ~sync1);
        end
    end

    assign step_rise = sync2 & ~prev & armed;
    assign advance   = ~hold & (mode ? step_rise : tick_w);

    always_ff @(posedge clock50Mhz) begin
        if (!reset) begin
            state <= S_ADD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (advance) begin
            state_nx = state_succ(state);
        end
    end

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic [WIDTH-1:0] res;
    logic [3:0]       fl;

    always_comb begin
        sum_ext = {1'b0, InputA} + {1'b0, InputB};
        dif_ext = {1'b0, InputA} - {1'b0, InputB};
        res     = '0;
        fl      = '0;
        unique case (state)
            S_ADD: begin
                res        = sum_ext[M:0];
                fl[FLAG_C] = sum_ext[WIDTH];
                fl[FLAG_V] = (InputA[M] == InputB[M]) &&
                             (res[M] != InputA[M]);
            end
            S_SUB: begin
                res        = dif_ext[M:0];
                fl[FLAG_C] = dif_ext[WIDTH];
                fl[FLAG_V] = (InputA[M] != InputB[M]) &&
                             (res[M] != InputA[M]);
            end
            S_AND:  res = InputA & InputB;
            S_OR:   res = InputA | InputB;
            S_XOR:  res = InputA ^ InputB;
            S_NOTA: res = ~InputA;
            S_SHL: begin
                res        = {InputA[M-1:0], 1'b0};
                fl[FLAG_C] = InputA[M];
            end
            S_SHR: begin
                res        = {1'b0, InputA[M:1]};
                fl[FLAG_C] = InputA[0];
            end
            default: res = '0;
        endcase
        fl[FLAG_Z] = (res == '0);
        fl[FLAG_N] = res[M];
    end

    always_ff @(posedge clock50Mhz) begin
        if (!reset) begin
            AluOut <= '0;
            Flags  <= '0;
        end else begin
            AluOut <= res;
            Flags  <= fl;
        end
    end

    assign PrStateLed = state;
    assign NxStateLed = state_succ(state);
    assign tick       = tick_w;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised and directed stimulus for alu_sequencer, checked by a
// scoreboard against an arithmetic reference model.
module tb_alu_sequencer;

    localparam int W  = 4;
    localparam int TD = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] InputA = '0;
    logic [W-1:0] InputB = '0;
    logic         mode = 1'b0;
    logic         step = 1'b0;
    logic         hold = 1'b0;
    logic [W-1:0] AluOut;
    logic [3:0]   Flags;
    logic [2:0]   PrStateLed;
    logic [2:0]   NxStateLed;
    logic         tick;

    alu_sequencer #(.WIDTH(W), .TICK_DIV(TD)) dut (
        .clock50Mhz(clk),
        .reset     (reset),
        .InputA    (InputA),
        .InputB    (InputB),
        .mode      (mode),
        .step      (step),
        .hold      (hold),
        .AluOut    (AluOut),
        .Flags     (Flags),
        .PrStateLed(PrStateLed),
        .NxStateLed(NxStateLed),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int nx;
        int alu;
        int fl;
        int tk;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    int   m_state = 0;
    int   m_cnt = 0;
    bit   hist[$];
    bit   cur_md = 1'b0;
    bit   cur_st = 1'b0;

    function automatic int sgn(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    function automatic int alu_ref(input int op, input int a, input int b);
        int res, c, v, sv;
        c = 0;
        v = 0;
        case (op)
            0: begin
                res = (a + b) % 16;
                c   = (a + b > 15) ? 1 : 0;
                sv  = sgn(a) + sgn(b);
                v   = (sv > 7 || sv < -8) ? 1 : 0;
            end
            1: begin
                res = (a - b + 16) % 16;
                c   = (a < b) ? 1 : 0;
                sv  = sgn(a) - sgn(b);
                v   = (sv > 7 || sv < -8) ? 1 : 0;
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = 15 - a;
            6: begin
                res = (a * 2) % 16;
                c   = (a >= 8) ? 1 : 0;
            end
            default: begin
                res = a / 2;
                c   = a % 2;
            end
        endcase
        return (res << 4) | ((res >= 8) ? 8 : 0) | (v << 2)
               | ((res == 0) ? 2 : 0) | c;
    endfunction

    task automatic model_edge(input bit r, input int a, input int b,
                              input bit md, input bit stp, input bit hd);
        exp_t e;
        int   n, packed_r;
        bit   rise, adv;
        if (!r) begin
            m_state = 0;
            m_cnt   = 0;
            hist.delete();
            e = '{0, 1, 0, 0, 0};
        end else begin
            packed_r = alu_ref(m_state, a, b);
            hist.push_back(stp);
            n    = hist.size();
            // a press is an observed low followed by a high, seen 2 edges late
            rise = (n >= 4) && !hist[n-4] && hist[n-3];
            adv  = !hd && (md ? rise : (m_cnt == TD - 1));
            m_cnt = md ? 0 : (m_cnt + 1) % TD;
            if (adv) m_state = (m_state + 1) % 8;
            e = '{m_state, (m_state + 1) % 8, packed_r >> 4,
                  packed_r & 15, (m_cnt == TD - 1) ? 1 : 0};
        end
        q.push_back(e);
    endtask

    task automatic cyc(input bit r, input int a, input int b,
                       input bit md, input bit stp, input bit hd);
        @(negedge clk);
        reset  = r;
        InputA = a[W-1:0];
        InputB = b[W-1:0];
        mode   = md;
        step   = stp;
        hold   = hd;
        model_edge(r, a, b, md, stp, hd);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("PrStateLed", int'(PrStateLed), e.st);
                chk("NxStateLed", int'(NxStateLed), e.nx);
                chk("AluOut", int'(AluOut), e.alu);
                chk("Flags", int'(Flags), e.fl);
                chk("tick", int'(tick), e.tk);
            end
        end
    end

    int a_tab[8] = '{9, 3, 5, 12, 6, 9, 9, 9};
    int b_tab[8] = '{8, 5, 10, 3, 3, 0, 0, 0};

    initial begin : driver
        int guard;
        repeat (3) cyc(0, 9, 8, 0, 0, 0);

        for (int s = 0; s < 9; s++)
            for (int k = 0; k < 4; k++)
                cyc(1, a_tab[s % 8], b_tab[s % 8], 0, 0, 0);

        repeat (3) cyc(1, $urandom_range(0, 15), $urandom_range(0, 15), 1, 0, 0);
        repeat (6) cyc(1, $urandom_range(0, 15), $urandom_range(0, 15), 1, 1, 0);
        repeat (4) cyc(1, $urandom_range(0, 15), $urandom_range(0, 15), 1, 0, 0);
        repeat (2) cyc(1, 7, 2, 1, 0, 1);
        repeat (5) cyc(1, 7, 2, 1, 1, 1);
        repeat (3) cyc(1, 7, 2, 1, 0, 1);
        repeat (4) cyc(1, 7, 2, 1, 0, 0);

        guard = 0;
        while (!(m_state == 5 && m_cnt == 2) && guard < 100) begin
            cyc(1, 4, 1, 0, 0, 0);
            guard++;
        end
        chk("reach_s5_c2", guard < 100 ? 1 : 0, 1);
        cyc(0, 4, 1, 0, 0, 0);
        repeat (2) cyc(1, 4, 1, 1, 0, 0);
        repeat (2) cyc(0, 4, 1, 1, 1, 0);
        repeat (6) cyc(1, 4, 1, 1, 1, 0);
        repeat (3) cyc(1, 4, 1, 1, 0, 0);
        repeat (4) cyc(1, 4, 1, 1, 1, 0);
        repeat (3) cyc(1, 4, 1, 1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) cur_md = ~cur_md;
            if ($urandom_range(0, 3) == 0) cur_st = ~cur_st;
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 15), $urandom_range(0, 15),
                cur_md, cur_st, $urandom_range(0, 7) == 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
